// File: rtl/mack_bus_controller_if.sv
// CPU-side bus bundle for the 68000 bus controller: address/strobe inputs,
// chip selects and acknowledge/error outputs.
interface mack_bus_controller_if #(
  parameter int unsigned NUM_CS = 4
) ();
  logic [8:0]        addr;
  logic              as;
  logic              iack;
  logic              dtack_in;
  logic [NUM_CS-1:0] cs;
  logic              dtack;
  logic              berr;
  logic              boot_done;

  modport master (
    output addr, as, iack, dtack_in,
    input  cs, dtack, berr, boot_done
  );

  modport slave (
    input  addr, as, iack, dtack_in,
    output cs, dtack, berr, boot_done
  );
endinterface

// File: rtl/mack_bus_controller.sv
// 68000 bus controller: chip-select decode with boot ROM overlay, per-region
// DTACK from a wait-state counter or DTACK_IN, and a bus-error watchdog.
module mack_bus_controller #(
  parameter int unsigned         NUM_CS       = 4,
  parameter int unsigned         BOOT_CYCLES  = 8,
  parameter int unsigned         ROM_CS       = 0,
  parameter logic [NUM_CS*9-1:0] CS_BASE      = {9'h000, 9'h07C, 9'h078, 9'h070},
  parameter logic [NUM_CS*9-1:0] CS_MASK      = {9'h000, 9'h1FC, 9'h1FC, 9'h1F8},
  parameter logic [NUM_CS*4-1:0] CS_WAIT      = {4'd1, 4'd2, 4'd0, 4'd1},
  parameter logic [NUM_CS-1:0]   CS_EXTDTACK  = 4'b0010,
  parameter int unsigned         BERR_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  mack_bus_controller_if.slave bus
);

  localparam int unsigned SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned BOOT_W = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam int unsigned TMR_W  = $clog2(BERR_TIMEOUT) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_FAULT} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic                boot_done_q, boot_done_d;
  logic                lat_ext_q, lat_ext_d;
  logic                lat_miss_q, lat_miss_d;
  logic                ack;

  logic                hit_any;
  logic [SEL_W-1:0]    hit_sel;
  logic [SEL_W-1:0]    sel;
  logic                miss;
  logic [3:0]          sel_wait;
  logic                sel_ext;
  logic [NUM_CS-1:0]   cs_c;

  // Lowest-index region whose masked base matches the address wins
  always_comb begin
    hit_any = 1'b0;
    hit_sel = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (!hit_any && (((bus.addr ^ CS_BASE[i*9 +: 9]) & CS_MASK[i*9 +: 9]) == 9'h000)) begin
        hit_any = 1'b1;
        hit_sel = SEL_W'(i);
      end
    end
  end

  // Until boot completes every cycle is steered to the ROM region
  assign sel  = boot_done_q ? hit_sel : SEL_W'(ROM_CS);
  assign miss = boot_done_q & ~hit_any;

  always_comb begin
    sel_wait = 4'd0;
    sel_ext  = 1'b0;
    cs_c     = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_wait = CS_WAIT[i*4 +: 4];
        sel_ext  = CS_EXTDTACK[i];
        cs_c[i]  = ~(rst_n & ~bus.as & bus.iack & ~miss);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      timer_q     <= '0;
      boot_cnt_q  <= '0;
      boot_done_q <= 1'b0;
      lat_ext_q   <= 1'b0;
      lat_miss_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      timer_q     <= timer_d;
      boot_cnt_q  <= boot_cnt_d;
      boot_done_q <= boot_done_d;
      lat_ext_q   <= lat_ext_d;
      lat_miss_q  <= lat_miss_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    timer_d     = timer_q;
    boot_cnt_d  = boot_cnt_q;
    boot_done_d = boot_done_q;
    lat_ext_d   = lat_ext_q;
    lat_miss_d  = lat_miss_q;
    ack         = 1'b0;
    if (bus.as) begin
      state_d = ST_IDLE;
      wcnt_d  = '0;
      timer_d = '0;
      if (!boot_done_q && (boot_cnt_q == BOOT_W'(BOOT_CYCLES)))
        boot_done_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_WAIT;
          lat_ext_d  = ~bus.iack | sel_ext;
          lat_miss_d = bus.iack & miss;
          wcnt_d     = sel_wait;
          timer_d    = '0;
          if (!boot_done_q && (boot_cnt_q != BOOT_W'(BOOT_CYCLES)))
            boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
        ST_WAIT: begin
          // IACK and external regions wait for DTACK_IN; misses only time out
          if (lat_ext_q)
            ack = ~bus.dtack_in;
          else if (!lat_miss_q) begin
            ack = (wcnt_q == 4'd0);
            if (wcnt_q != 4'd0)
              wcnt_d = wcnt_q - 4'd1;
          end
          if (ack)
            state_d = ST_ACK;
          else if (timer_q == TMR_W'(BERR_TIMEOUT - 1))
            state_d = ST_FAULT;
          else
            timer_d = timer_q + TMR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Strobes gate DTACK/BERR so both release the instant AS rises
  assign bus.cs        = cs_c;
  assign bus.dtack     = ~((state_q == ST_ACK) & ~bus.as);
  assign bus.berr      = ~((state_q == ST_FAULT) & ~bus.as);
  assign bus.boot_done = boot_done_q;

endmodule
